// File: rtl/flash_cmd_sequencer.sv
// rtl/flash_cmd_sequencer.sv - host-side four-cycle unlock/command bus sequencer for the flash interface
// Optional abort support is compiled in with FLASH_SEQ_ABORT_EN.
module flash_cmd_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        flash_en,
    output logic [15:0] flash_addr,
    output logic [7:0]  flash_data_out,
    output logic        flash_data_oe,
    input  logic [7:0]  flash_data_in
`ifdef FLASH_SEQ_ABORT_EN
    ,
    input  logic        abort,
    output logic        aborted
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] timer;
    logic [15:0] timer_nxt;
    logic [1:0]  step;
    logic        op_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;

    logic        phase_end;
    logic        start;
    logic        advance;
    logic        finish;
    logic        capture;
    logic        abort_hit;
    logic [1:0]  word_step;
    logic [15:0] word_addr;
    logic [7:0]  word_data;

`ifdef FLASH_SEQ_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign phase_end = (timer == 16'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nxt = SETUP;
                    start     = 1'b1;
                end
            end
            SETUP: if (phase_end) state_nxt = PULSE;
            PULSE: if (phase_end) state_nxt = HOLD;
            HOLD: begin
                if (phase_end) begin
                    if (step == 2'd3) begin
                        state_nxt = IDLE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = SETUP;
                        advance   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = IDLE;
            advance   = 1'b0;
            finish    = 1'b0;
        end
    end

    // Every phase change is also a state change, so the timer reloads on any state change.
    always_comb begin
        timer_nxt = timer;
        if (state_nxt != state) begin
            case (state_nxt)
                SETUP:   timer_nxt = 16'(SETUP_CYC - 1);
                PULSE:   timer_nxt = 16'(PULSE_CYC - 1);
                HOLD:    timer_nxt = 16'(HOLD_CYC - 1);
                default: timer_nxt = 16'd0;
            endcase
        end else if (timer != 16'd0) begin
            timer_nxt = timer - 16'd1;
        end
    end

    // Bus word for the step about to enter SETUP; step 0 never depends on latched fields.
    always_comb begin
        word_step = start ? 2'd0 : step + 2'd1;
        word_addr = 16'h5555;
        word_data = 8'hAA;
        case (word_step)
            2'd0: begin
                word_addr = 16'h5555;
                word_data = 8'hAA;
            end
            2'd1: begin
                word_addr = 16'hAAAA;
                word_data = 8'h55;
            end
            2'd2: begin
                word_addr = 16'h5555;
                word_data = op_q ? 8'h00 : 8'h20;
            end
            default: begin
                word_addr = addr_q;
                word_data = op_q ? 8'h00 : wdata_q;
            end
        endcase
    end

    assign capture = (state == PULSE) && phase_end && (step == 2'd3) && op_q && !abort_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer          <= 16'd0;
            step           <= 2'd0;
            op_q           <= 1'b0;
            addr_q         <= 16'd0;
            wdata_q        <= 8'd0;
            flash_addr     <= 16'd0;
            flash_data_out <= 8'd0;
            rdata          <= 8'd0;
            done           <= 1'b0;
        end else begin
            timer <= timer_nxt;
            done  <= finish;
            if (start) begin
                op_q    <= op;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (start || advance) begin
                step           <= word_step;
                flash_addr     <= word_addr;
                flash_data_out <= word_data;
            end
            if (capture) begin
                rdata <= flash_data_in;
            end
        end
    end

`ifdef FLASH_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aborted <= 1'b0;
        end else begin
            aborted <= abort_hit;
        end
    end
`endif

    assign ready         = (state == IDLE);
    assign flash_en      = (state == PULSE);
    // A read releases the data bus for the target cycle so the flash can drive it.
    assign flash_data_oe = (state != IDLE) && !(op_q && (step == 2'd3));

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// tb/tb_flash_cmd_sequencer.sv - directed self-checking bench for flash_cmd_sequencer
module tb_flash_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ready;
    logic        done;
    logic [7:0]  rdata;
    logic        flash_en;
    logic [15:0] flash_addr;
    logic [7:0]  flash_data_out;
    logic        flash_data_oe;
    logic [7:0]  flash_data_in;
    logic        abort;
    logic        aborted;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    flash_cmd_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .op             (op),
        .addr           (addr),
        .wdata          (wdata),
        .ready          (ready),
        .done           (done),
        .rdata          (rdata),
        .flash_en       (flash_en),
        .flash_addr     (flash_addr),
        .flash_data_out (flash_data_out),
        .flash_data_oe  (flash_data_oe),
        .flash_data_in  (flash_data_in)
`ifdef FLASH_SEQ_ABORT_EN
        ,
        .abort          (abort),
        .aborted        (aborted)
`endif
    );

`ifndef FLASH_SEQ_ABORT_EN
    assign aborted = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request starting in the current cycle N and checks every cycle through done (N+17).
    task automatic run_seq(input logic rd, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] din, input logic [7:0] exp_rdata,
                           input bit busy_poke, input bit hold_req);
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        logic        e_oe;
        int          st;
        int          ph;
        req   = 1'b1;
        op    = rd;
        addr  = a;
        wdata = wd;
        check("accept_ready", ready, 1);
        for (int cyc = 1; cyc <= 17; cyc++) begin
            @(negedge clk);
            if (!hold_req) req = 1'b0;
            if (busy_poke && cyc == 5) begin
                req   = 1'b1;
                op    = ~rd;
                addr  = 16'hFFFF;
                wdata = 8'hFF;
            end
            if (cyc <= 16) begin
                st = (cyc - 1) / 4;
                ph = (cyc - 1) % 4;
                flash_data_in = (st == 3 && (ph == 1 || ph == 2)) ? din : 8'h11;
                case (st)
                    0: begin e_addr = 16'h5555; e_data = 8'hAA; e_oe = 1'b1; end
                    1: begin e_addr = 16'hAAAA; e_data = 8'h55; e_oe = 1'b1; end
                    2: begin e_addr = 16'h5555; e_data = rd ? 8'h00 : 8'h20; e_oe = 1'b1; end
                    default: begin e_addr = a; e_data = rd ? 8'h00 : wd; e_oe = !rd; end
                endcase
                check($sformatf("c%0d_en", cyc), flash_en, (ph == 1 || ph == 2));
                check($sformatf("c%0d_addr", cyc), flash_addr, e_addr);
                check($sformatf("c%0d_data", cyc), flash_data_out, e_data);
                check($sformatf("c%0d_oe", cyc), flash_data_oe, e_oe);
                check($sformatf("c%0d_ready", cyc), ready, 0);
                check($sformatf("c%0d_done", cyc), done, 0);
            end else begin
                check("done_pulse", done, 1);
                check("done_ready", ready, 1);
                check("done_en", flash_en, 0);
                check("done_oe", flash_data_oe, 0);
                check("done_rdata", rdata, exp_rdata);
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        req           = 1'b0;
        op            = 1'b0;
        addr          = 16'h0000;
        wdata         = 8'h00;
        flash_data_in = 8'h00;
        abort         = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_rdata", rdata, 0);
        check("rst_en", flash_en, 0);
        check("rst_addr", flash_addr, 0);
        check("rst_data", flash_data_out, 0);
        check("rst_oe", flash_data_oe, 0);
        check("rst_aborted", aborted, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Write 1234/5A
        run_seq(1'b0, 16'h1234, 8'h5A, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        check("w_done_clear", done, 0);
        check("w_idle_addr", flash_addr, 16'h1234);
        check("w_idle_data", flash_data_out, 8'h5A);

        // Read 0042, flash returns C3 during step 3 pulse
        run_seq(1'b1, 16'h0042, 8'h99, 8'hC3, 8'hC3, 1'b0, 1'b0);
        @(negedge clk);
        check("r_done_clear", done, 0);

        // Busy request during step 1 is ignored; one done only
        run_seq(1'b0, 16'h0F0F, 8'hA5, 8'h00, 8'hC3, 1'b1, 1'b0);
        @(negedge clk);
        check("busy_single_done", done, 0);
        check("busy_ready", ready, 1);
        @(negedge clk);
        check("busy_no_restart", ready, 1);

        // Reset during step 2 pulse
        req   = 1'b1;
        op    = 1'b0;
        addr  = 16'h7777;
        wdata = 8'h33;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("pre_rst_en", flash_en, 1);
        check("pre_rst_addr", flash_addr, 16'h5555);
        reset = 1'b0;
        #1;
        check("mid_rst_en", flash_en, 0);
        check("mid_rst_ready", ready, 1);
        check("mid_rst_addr", flash_addr, 0);
        check("mid_rst_oe", flash_data_oe, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_done", done, 0);

        // Back-to-back: write then read with req held high
        run_seq(1'b0, 16'hBEEF, 8'h77, 8'h00, 8'h00, 1'b0, 1'b1);
        run_seq(1'b1, 16'h0042, 8'h00, 8'h96, 8'h96, 1'b0, 1'b0);
        @(negedge clk);
        check("b2b_done_clear", done, 0);
        check("b2b_ready", ready, 1);

`ifdef FLASH_SEQ_ABORT_EN
        // Abort during step 1 pulse
        req   = 1'b1;
        op    = 1'b0;
        addr  = 16'h2222;
        wdata = 8'h44;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            req = 1'b0;
        end
        check("ab_pre_en", flash_en, 1);
        check("ab_pre_addr", flash_addr, 16'hAAAA);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("ab_en", flash_en, 0);
        check("ab_oe", flash_data_oe, 0);
        check("ab_pulse", aborted, 1);
        check("ab_done", done, 0);
        check("ab_ready", ready, 1);
        @(negedge clk);
        check("ab_pulse_clear", aborted, 0);
        check("ab_done_late", done, 0);
        check("ab_rdata", rdata, 8'h96);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
